key_event_buffer: RTL and testbench

- Synchronous FIFO sitting directly upstream of the audio processor.
- Queues key/menu events from the keypad/keyboard decoder.
- Presents the oldest event on evt; pops it when the processor pulses clear_evt.
- Code 8'h00 is reserved as "no event". evt reads 8'h00 whenever the buffer is empty, so the processor controller idles.

---
 rtl/audio_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/key_event_buffer.sv | 79 +++++++
 tb/tb_key_event_buffer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Event codes and widths shared by the key event buffer and processor decode.
// Also holds the FIFO operation encoding used by sync_fifo.
package audio_pkg;

    localparam int EVT_WIDTH = 8;

    localparam logic [EVT_WIDTH-1:0] EVT_NONE         = 8'h00;
    localparam logic [EVT_WIDTH-1:0] EVT_KEY_PRESS    = 8'h10;
    localparam logic [EVT_WIDTH-1:0] EVT_KEY_RELEASE  = 8'h20;
    localparam logic [EVT_WIDTH-1:0] EVT_INCREASE     = 8'h40;
    localparam logic [EVT_WIDTH-1:0] EVT_DECREASE     = 8'h41;
    localparam logic [EVT_WIDTH-1:0] EVT_MENU_CHANGE  = 8'h42;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_BOTH
    } fifo_op_e;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO: storage, wrapping pointers, separate count.
// Ports: clk, rst_n, push/wdata, pop/rdata, count, full, empty.
module sync_fifo
    import audio_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    fifo_op_e         op;

    always_comb begin
        op = OP_IDLE;
        if (push && pop) op = OP_BOTH;
        else if (push)   op = OP_PUSH;
        else if (pop)    op = OP_POP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            unique case (op)
                OP_PUSH: begin
                    wr_ptr <= wr_ptr + AW'(1);
                    count  <= count + CW'(1);
                end
                OP_POP: begin
                    rd_ptr <= rd_ptr + AW'(1);
                    count  <= count - CW'(1);
                end
                OP_BOTH: begin
                    wr_ptr <= wr_ptr + AW'(1);
                    rd_ptr <= rd_ptr + AW'(1);
                end
                default: ;
            endcase
        end
    end

    // Storage needs no reset; contents are qualified by count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/key_event_buffer.sv
// Key/menu event queue feeding the audio processor; evt reads 0 when empty.
// Ports: clk, reset (async, active-low), in_evt/in_valid, clear_evt, evt, count, full, overflow.
// Optional duplicate suppression with KEY_EVENT_DEDUP_EN.
module key_event_buffer
    import audio_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = EVT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       in_evt,
    input  logic                   in_valid,
    input  logic                   clear_evt,
    output logic [WIDTH-1:0]       evt,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   overflow
);

    logic [WIDTH-1:0] head;
    logic             empty;
    logic             pop;
    logic             push;
    logic             qualified;
    logic             drop;
    logic             dup;

    assign pop       = clear_evt && !empty;
    assign qualified = in_valid && (in_evt != '0) && !dup;
    // A same-cycle pop frees the slot, so a full buffer still accepts.
    assign push      = qualified && (!full || pop);
    assign drop      = qualified && full && !pop;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (push),
        .wdata (in_evt),
        .pop   (pop),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign evt = empty ? '0 : head;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
    end

`ifdef KEY_EVENT_DEDUP_EN
    logic [WIDTH-1:0] last_evt;
    logic             last_valid;

    // last_valid mirrors "last accepted event still buffered".
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_evt   <= '0;
            last_valid <= 1'b0;
        end else if (push) begin
            last_evt   <= in_evt;
            last_valid <= 1'b1;
        end else if (pop && count == 1) begin
            last_valid <= 1'b0;
        end
    end

    assign dup = last_valid && (in_evt == last_evt);
`else
    assign dup = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_buffer.sv
// Self-checking bench for key_event_buffer against a queue-based model.
// Directed scenarios followed by randomized traffic.
module tb_key_event_buffer;

    localparam int DEPTH = 8;
`ifdef KEY_EVENT_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_evt = '0;
    logic       in_valid = 1'b0;
    logic       clear_evt = 1'b0;
    logic [7:0] evt;
    logic [3:0] count;
    logic       full;
    logic       overflow;

    int total = 0;
    int bad = 0;

    logic [7:0] mq[$];
    logic       m_ovf = 1'b0;
    logic [7:0] m_last = '0;

    key_event_buffer #(.DEPTH(DEPTH), .WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_evt    (in_evt),
        .in_valid  (in_valid),
        .clear_evt (clear_evt),
        .evt       (evt),
        .count     (count),
        .full      (full),
        .overflow  (overflow)
    );

    always #10 clk = ~clk;

    function automatic logic [7:0] m_evt();
        return (mq.size() != 0) ? mq[0] : 8'h00;
    endfunction

    task automatic model(input logic v, input logic [7:0] e, input logic c);
        bit p, d, q;
        p = c && (mq.size() != 0);
        d = DEDUP && (mq.size() != 0) && (e == m_last);
        q = v && (e != 8'h00) && !d;
        if (p) void'(mq.pop_front());
        if (q) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(e);
                m_last = e;
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    // Drive at negedge, clock once, return at the following negedge.
    task automatic step(input logic v, input logic [7:0] e, input logic c);
        in_valid = v;
        in_evt = e;
        clear_evt = c;
        @(posedge clk);
        model(v, e, c);
        @(negedge clk);
        in_valid = 1'b0;
        in_evt = 8'h00;
        clear_evt = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        mq.delete();
        m_ovf = 1'b0;
        m_last = '0;
    endtask

    task automatic test_reset();
        do_reset();
        total += 4;
        if (evt !== 8'h00) begin bad++; $display("FAIL reset_evt got %h want 00", evt); end
        if (count !== 4'd0) begin bad++; $display("FAIL reset_count got %0d want 0", count); end
        if (full !== 1'b0) begin bad++; $display("FAIL reset_full got %b want 0", full); end
        if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got %b want 0", overflow); end
        step(1'b0, 8'h00, 1'b1);
        total += 2;
        if (evt !== 8'h00) begin bad++; $display("FAIL empty_pop_evt got %h want 00", evt); end
        if (count !== 4'd0) begin bad++; $display("FAIL empty_pop_count got %0d want 0", count); end
    endtask

    task automatic test_basic();
        logic [7:0] exp_seq [3];
        exp_seq[0] = 8'h22;
        exp_seq[1] = 8'h23;
        exp_seq[2] = 8'h00;
        do_reset();
        step(1'b1, 8'h21, 1'b0);
        total++;
        if (evt !== 8'h21) begin bad++; $display("FAIL first_latency got %h want 21", evt); end
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h23, 1'b0);
        total++;
        if (count !== 4'd3) begin bad++; $display("FAIL basic_count got %0d want 3", count); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b1);
            total++;
            if (evt !== exp_seq[i]) begin
                bad++;
                $display("FAIL basic_pop%0d got %h want %h", i, evt, exp_seq[i]);
            end
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 8'(i), 1'b0);
        total++;
        if (full !== 1'b1) begin bad++; $display("FAIL full_flag got %b want 1", full); end
        step(1'b1, 8'h09, 1'b0);
        total += 2;
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got %b want 1", overflow); end
        if (count !== 4'd8) begin bad++; $display("FAIL ovf_count got %0d want 8", count); end
        for (int i = 1; i <= DEPTH; i++) begin
            total++;
            if (evt !== 8'(i)) begin bad++; $display("FAIL drain%0d got %h want %h", i, evt, 8'(i)); end
            step(1'b0, 8'h00, 1'b1);
        end
        total += 2;
        if (count !== 4'd0) begin bad++; $display("FAIL drain_count got %0d want 0", count); end
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b1, 8'h0A, 1'b1);
        total += 3;
        if (count !== 4'd8) begin bad++; $display("FAIL fpp_count got %0d want 8", count); end
        if (evt !== 8'h02) begin bad++; $display("FAIL fpp_head got %h want 02", evt); end
        if (overflow !== 1'b0) begin bad++; $display("FAIL fpp_ovf got %b want 0", overflow); end
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 8'h00, 1'b1);
        total++;
        if (evt !== 8'h0A) begin bad++; $display("FAIL fpp_tail got %h want 0A", evt); end
    endtask

    task automatic test_zero_and_async_reset();
        do_reset();
        step(1'b1, 8'h55, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        total++;
        if (count !== 4'd1) begin bad++; $display("FAIL zero_code got %0d want 1", count); end
        for (int i = 0; i < 4; i++) step(1'b1, 8'h60 + 8'(i), 1'b0);
        total++;
        if (count !== 4'd5) begin bad++; $display("FAIL pre_reset_count got %0d want 5", count); end
        #3 reset = 1'b0;
        #1;
        total += 3;
        if (evt !== 8'h00) begin bad++; $display("FAIL async_evt got %h want 00", evt); end
        if (count !== 4'd0) begin bad++; $display("FAIL async_count got %0d want 0", count); end
        if (overflow !== 1'b0) begin bad++; $display("FAIL async_ovf got %b want 0", overflow); end
        @(negedge clk);
        reset = 1'b1;
        mq.delete();
        m_ovf = 1'b0;
    endtask

    task automatic test_dedup();
        logic [3:0] want3, want_after;
        want3 = DEDUP ? 4'd2 : 4'd3;
        want_after = DEDUP ? 4'd1 : 4'd2;
        do_reset();
        step(1'b1, 8'h30, 1'b0);
        step(1'b1, 8'h30, 1'b0);
        step(1'b1, 8'h31, 1'b0);
        total++;
        if (count !== want3) begin bad++; $display("FAIL dedup_count got %0d want %0d", count, want3); end
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h31, 1'b0);
        total += 2;
        if (count !== want_after) begin
            bad++;
            $display("FAIL dedup_reaccept got %0d want %0d", count, want_after);
        end
        if (overflow !== 1'b0) begin bad++; $display("FAIL dedup_ovf got %b want 0", overflow); end
    endtask

    task automatic test_random();
        logic [7:0] pool [4];
        logic [7:0] e;
        pool[0] = 8'h00;
        pool[1] = 8'h30;
        pool[2] = 8'h31;
        pool[3] = 8'h42;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) e = 8'($urandom);
            else e = pool[$urandom_range(0, 3)];
            step(($urandom_range(0, 9) < 6), e, ($urandom_range(0, 9) < (n < 300 ? 3 : 6)));
            total += 4;
            if (evt !== m_evt()) begin bad++; $display("FAIL rnd_evt n=%0d got %h want %h", n, evt, m_evt()); end
            if (count !== 4'(mq.size())) begin
                bad++;
                $display("FAIL rnd_count n=%0d got %0d want %0d", n, count, mq.size());
            end
            if (full !== (mq.size() == DEPTH)) begin bad++; $display("FAIL rnd_full n=%0d got %b", n, full); end
            if (overflow !== m_ovf) begin
                bad++;
                $display("FAIL rnd_ovf n=%0d got %b want %b", n, overflow, m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_full_push_pop();
        test_zero_and_async_reset();
        test_dedup();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
